// File: rtl/hs_mem_pkg.sv
// ---------------------------------------------------------------------------
// hs_mem_pkg
// Shared types for the handshake memory bank: the per-channel load FSM and
// the store FSM state enums, plus the saturation limit of the debug counter.
// No ports.
// ---------------------------------------------------------------------------
package hs_mem_pkg;

    typedef enum logic {
        LD_IDLE = 1'b0,
        LD_PEND = 1'b1
    } ld_state_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_DONE = 1'b1
    } st_state_t;

    localparam logic [31:0] ACC_CNT_MAX = 32'hFFFF_FFFF;

endpackage

// File: rtl/hs_mem_bank_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Round-robin arbiter over N requesters. At most one grant per cycle. After
// a grant the priority pointer moves to the slot after the winner, so the
// winner becomes lowest priority next time. Pointer resets to slot 0.
//
// Ports
//   clock      in   rising-edge clock
//   reset      in   synchronous active-high reset
//   req_i      in   [N]  request vector
//   gnt_o      out  [N]  one-hot grant (all zero when nobody requests)
//   gnt_any_o  out       a grant is issued this cycle
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N = 3,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [N-1:0] req_i,
    output logic [N-1:0] gnt_o,
    output logic         gnt_any_o
);

    logic [IW-1:0] ptr_q;
    logic [IW-1:0] ptr_d;
    logic [IW-1:0] slot;
    logic [IW-1:0] win;
    logic          found;

    // Search starts at the pointer and wraps; the first requester found wins.
    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        win   = '0;
        slot  = '0;
        for (int off = 0; off < N; off++) begin
            slot = IW'((int'(ptr_q) + off) % N);
            if (!found && req_i[slot]) begin
                found       = 1'b1;
                win         = slot;
                gnt_o[slot] = 1'b1;
            end
        end
    end

    assign gnt_any_o = found;

    always_comb begin
        ptr_d = ptr_q;
        if (found) begin
            ptr_d = (win == IW'(N - 1)) ? '0 : win + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/hs_mem_bank.sv
// ---------------------------------------------------------------------------
// hs_mem_bank
// Single-port DEPTH x DATA_W storage shared by NUM_LD load channels and one
// store channel. Each channel holds at most one outstanding request; idle
// requesters are arbitrated round-robin (store is the last slot), so at most
// one array access happens per cycle. Load data is registered and held until
// taken; a store writes at acceptance and returns a done token. Addresses
// >= DEPTH read as 0 and never write. A backdoor preload port writes the
// array when the bank is quiet. Array contents survive reset.
//
// Ports
//   clock, reset                      clock / synchronous active-high reset
//   ld_addr_i        [NUM_LD*ADDR_W]  per-channel load address
//   ld_addr_valid_i / ld_addr_ready_o [NUM_LD]  address handshake
//   ld_data_o        [NUM_LD*DATA_W]  per-channel registered load data
//   ld_data_valid_o / ld_data_ready_i [NUM_LD]  data handshake
//   st_addr_i, st_data_i, st_valid_i / st_ready_o  store request
//   st_done_valid_o / st_done_ready_i              store completion token
//   wr_en_i, wr_addr_i, wr_data_i                  backdoor preload write
// ---------------------------------------------------------------------------
module hs_mem_bank
    import hs_mem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 16,
    parameter int NUM_LD = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NUM_LD*ADDR_W-1:0] ld_addr_i,
    input  logic [NUM_LD-1:0]        ld_addr_valid_i,
    output logic [NUM_LD-1:0]        ld_addr_ready_o,
    output logic [NUM_LD*DATA_W-1:0] ld_data_o,
    output logic [NUM_LD-1:0]        ld_data_valid_o,
    input  logic [NUM_LD-1:0]        ld_data_ready_i,
    input  logic [ADDR_W-1:0]        st_addr_i,
    input  logic [DATA_W-1:0]        st_data_i,
    input  logic                     st_valid_i,
    output logic                     st_ready_o,
    output logic                     st_done_valid_o,
    input  logic                     st_done_ready_i,
    input  logic                     wr_en_i,
    input  logic [ADDR_W-1:0]        wr_addr_i,
    input  logic [DATA_W-1:0]        wr_data_i
);

    localparam int NSLOT  = NUM_LD + 1;
    localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    if (DEPTH > (2 ** ADDR_W)) begin : g_bad_depth
        $error("hs_mem_bank: DEPTH exceeds the address space");
    end

    ld_state_t         ld_state_q [NUM_LD];
    ld_state_t         ld_state_d [NUM_LD];
    logic [DATA_W-1:0] ld_data_q  [NUM_LD];
    st_state_t         st_state_q;
    st_state_t         st_state_d;
    logic [DATA_W-1:0] mem_q      [DEPTH];
    logic [31:0]       acc_cnt_q;

    logic [NSLOT-1:0]  req;
    logic [NSLOT-1:0]  gnt;
    logic              gnt_any;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              busy;
    logic              st_wr;
    logic              bd_wr;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return 32'(a) < 32'(DEPTH);
    endfunction

    // Only idle requesters compete, so readies never see the downstream
    // data/done ready inputs.
    always_comb begin
        req = '0;
        for (int i = 0; i < NUM_LD; i++) begin
            req[i] = ld_addr_valid_i[i] && (ld_state_q[i] == LD_IDLE);
        end
        req[NUM_LD] = st_valid_i && (st_state_q == ST_IDLE);
    end

    rr_arbiter #(
        .N (NSLOT)
    ) u_arb (
        .clock     (clock),
        .reset     (reset),
        .req_i     (req),
        .gnt_o     (gnt),
        .gnt_any_o (gnt_any)
    );

    assign ld_addr_ready_o = gnt[NUM_LD-1:0];
    assign st_ready_o      = gnt[NUM_LD];

    // Read port: address of whichever load channel won this cycle.
    always_comb begin
        rd_addr = '0;
        for (int i = 0; i < NUM_LD; i++) begin
            if (gnt[i]) begin
                rd_addr = ld_addr_i[i*ADDR_W +: ADDR_W];
            end
        end
        rd_data = in_range(rd_addr) ? mem_q[rd_addr[MEM_AW-1:0]] : '0;
    end

    // The backdoor also stands down when a grant is issued in the same cycle,
    // keeping the array to one access per cycle.
    assign busy  = (|ld_data_valid_o) || (st_state_q == ST_DONE);
    assign st_wr = gnt[NUM_LD] && in_range(st_addr_i);
    assign bd_wr = wr_en_i && !busy && !gnt_any && in_range(wr_addr_i);

    always_comb begin
        for (int i = 0; i < NUM_LD; i++) begin
            ld_state_d[i] = ld_state_q[i];
            case (ld_state_q[i])
                LD_IDLE: if (gnt[i]) ld_state_d[i] = LD_PEND;
                LD_PEND: if (ld_data_ready_i[i]) ld_state_d[i] = LD_IDLE;
                default: ld_state_d[i] = LD_IDLE;
            endcase
        end
        st_state_d = st_state_q;
        case (st_state_q)
            ST_IDLE: if (gnt[NUM_LD]) st_state_d = ST_DONE;
            ST_DONE: if (st_done_ready_i) st_state_d = ST_IDLE;
            default: st_state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_LD; i++) begin
                ld_state_q[i] <= LD_IDLE;
                ld_data_q[i]  <= '0;
            end
            st_state_q <= ST_IDLE;
            acc_cnt_q  <= '0;
        end else begin
            for (int i = 0; i < NUM_LD; i++) begin
                ld_state_q[i] <= ld_state_d[i];
                if (gnt[i]) begin
                    ld_data_q[i] <= rd_data;
                end
            end
            st_state_q <= st_state_d;
            if (gnt_any && (acc_cnt_q != ACC_CNT_MAX)) begin
                acc_cnt_q <= acc_cnt_q + 32'd1;
            end
        end
    end

    // Storage is not reset; writes are blocked while reset is high so a
    // handshake that coincides with reset leaves the array untouched.
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (st_wr) begin
                mem_q[st_addr_i[MEM_AW-1:0]] <= st_data_i;
            end else if (bd_wr) begin
                mem_q[wr_addr_i[MEM_AW-1:0]] <= wr_data_i;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_LD; i++) begin
            ld_data_o[i*DATA_W +: DATA_W] = ld_data_q[i];
            ld_data_valid_o[i]            = (ld_state_q[i] == LD_PEND);
        end
    end

    assign st_done_valid_o = (st_state_q == ST_DONE);

endmodule

// File: tb/tb_hs_mem_bank.sv
module tb_hs_mem_bank;

    localparam int NSLOT = 3;
    localparam int DEP   = 12;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  ld_addr;
    logic [1:0]  ld_addr_valid, ld_addr_ready, ld_data_valid, ld_data_ready;
    logic [63:0] ld_data;
    logic [3:0]  st_addr, wr_addr;
    logic [31:0] st_data, wr_data;
    logic        st_valid, st_ready, st_done_valid, st_done_ready, wr_en;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic [3:0]  addr;
        logic [31:0] exp;
    } ld_vec_t;

    ld_vec_t tbl [10];

    // behavioural model state
    int          m_last;
    bit          m_pend [2];
    logic [31:0] m_data [2];
    bit          m_done;
    logic [31:0] m_mem  [DEP];

    hs_mem_bank #(
        .DATA_W (32),
        .ADDR_W (4),
        .DEPTH  (DEP),
        .NUM_LD (2)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .ld_addr_i       (ld_addr),
        .ld_addr_valid_i (ld_addr_valid),
        .ld_addr_ready_o (ld_addr_ready),
        .ld_data_o       (ld_data),
        .ld_data_valid_o (ld_data_valid),
        .ld_data_ready_i (ld_data_ready),
        .st_addr_i       (st_addr),
        .st_data_i       (st_data),
        .st_valid_i      (st_valid),
        .st_ready_o      (st_ready),
        .st_done_valid_o (st_done_valid),
        .st_done_ready_i (st_done_ready),
        .wr_en_i         (wr_en),
        .wr_addr_i       (wr_addr),
        .wr_data_i       (wr_data)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic sample();
        @(negedge clock);
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        ld_addr = '0; ld_addr_valid = '0; ld_data_ready = '0;
        st_addr = '0; st_data = '0; st_valid = 1'b0; st_done_ready = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic bd_write(input logic [3:0] a, input logic [31:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic load0(input logic [3:0] a, input logic [31:0] exp);
        ld_addr[3:0] = a; ld_addr_valid = 2'b01; ld_data_ready = 2'b01;
        sample();
        chk("tbl_ld_ready", ld_addr_ready, 2'b01);
        tick();
        ld_addr_valid = 2'b00;
        sample();
        chk("tbl_ld_valid", ld_data_valid, 2'b01);
        chk("tbl_ld_data", ld_data[31:0], exp);
        tick();
    endtask

    initial begin
        int g1;
        int win;
        bit busy;
        logic [2:0] r;

        tbl[0] = '{4'd3,  32'h11};
        tbl[1] = '{4'd5,  32'h22};
        tbl[2] = '{4'd7,  32'hDEAD};
        tbl[3] = '{4'd9,  32'h99};
        tbl[4] = '{4'd0,  32'hA0};
        tbl[5] = '{4'd11, 32'hB0B};
        tbl[6] = '{4'd12, 32'h0};
        tbl[7] = '{4'd13, 32'h0};
        tbl[8] = '{4'd14, 32'h0};
        tbl[9] = '{4'd15, 32'h0};

        idle_inputs();
        do_reset();
        sample();
        chk("rst_ld_valid", ld_data_valid, 2'b00);
        chk("rst_st_done", st_done_valid, 1'b0);
        chk("rst_ld_data", ld_data, 64'h0);
        chk("rst_ld_ready", ld_addr_ready, 2'b00);
        tick();

        bd_write(4'd3, 32'h11);
        bd_write(4'd5, 32'h22);
        bd_write(4'd0, 32'hA0);
        bd_write(4'd11, 32'hB0B);
        bd_write(4'd12, 32'h5555);

        // two loads in the same cycle: ch0 first, ch1 one cycle later
        ld_addr = {4'd5, 4'd3}; ld_addr_valid = 2'b11; ld_data_ready = 2'b11;
        sample();
        chk("rr_same_cycle_gnt0", ld_addr_ready, 2'b01);
        tick();
        ld_addr_valid = 2'b10;
        sample();
        chk("ld0_valid_k1", ld_data_valid, 2'b01);
        chk("ld0_data_k1", ld_data[31:0], 32'h11);
        chk("rr_same_cycle_gnt1", ld_addr_ready, 2'b10);
        tick();
        ld_addr_valid = 2'b00;
        sample();
        chk("ld1_valid_k2", ld_data_valid, 2'b10);
        chk("ld1_data_k2", ld_data[63:32], 32'h22);
        tick();

        // store then load of the same address
        st_addr = 4'd7; st_data = 32'hDEAD; st_valid = 1'b1; st_done_ready = 1'b0;
        sample();
        chk("st_ready", st_ready, 1'b1);
        tick();
        ld_addr[3:0] = 4'd7; ld_addr_valid = 2'b01; ld_data_ready = 2'b01;
        sample();
        chk("st_done_set", st_done_valid, 1'b1);
        chk("st_ready_busy", st_ready, 1'b0);
        chk("raw_ld_ready", ld_addr_ready, 2'b01);
        tick();
        st_valid = 1'b0; ld_addr_valid = 2'b00;
        sample();
        chk("raw_ld_data", ld_data[31:0], 32'hDEAD);
        chk("st_done_held0", st_done_valid, 1'b1);
        tick();
        sample();
        chk("st_done_held1", st_done_valid, 1'b1);
        st_done_ready = 1'b1;
        tick();
        st_done_ready = 1'b0;
        sample();
        chk("st_done_clear", st_done_valid, 1'b0);
        tick();

        // ch0 back-pressured for 5 cycles while ch1 keeps loading
        ld_addr = {4'd5, 4'd3}; ld_addr_valid = 2'b01; ld_data_ready = 2'b10;
        sample();
        chk("bp_gnt0", ld_addr_ready, 2'b01);
        tick();
        ld_addr_valid = 2'b11;
        wr_en = 1'b1; wr_addr = 4'd0; wr_data = 32'hFFFF;
        g1 = 0;
        for (int c = 0; c < 5; c++) begin
            sample();
            chk("bp_ld0_data", ld_data[31:0], 32'h11);
            chk("bp_ld0_valid", ld_data_valid[0], 1'b1);
            chk("bp_ld0_ready", ld_addr_ready[0], 1'b0);
            if (ld_addr_ready[1]) g1++;
            tick();
        end
        wr_en = 1'b0;
        chk("bp_ch1_grants", g1, 3);
        ld_addr_valid = 2'b00; ld_data_ready = 2'b11;
        tick();
        tick();

        // out-of-range store still completes
        st_addr = 4'd13; st_data = 32'hBEEF; st_valid = 1'b1; st_done_ready = 1'b1;
        sample();
        chk("oor_st_ready", st_ready, 1'b1);
        tick();
        st_valid = 1'b0;
        sample();
        chk("oor_st_done", st_done_valid, 1'b1);
        tick();
        sample();
        chk("oor_st_done_clr", st_done_valid, 1'b0);
        tick();

        // all requesters continuously valid: strict rotation
        do_reset();
        ld_addr = '0; st_addr = 4'd15; st_data = 32'h0;
        ld_addr_valid = 2'b11; st_valid = 1'b1;
        ld_data_ready = 2'b11; st_done_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            sample();
            chk("rr_rotation", {st_ready, ld_addr_ready}, 3'b001 << (c % 3));
            tick();
        end
        ld_addr_valid = 2'b00; st_valid = 1'b0;
        tick();
        tick();

        // reset with a load and a store token both outstanding
        ld_addr[3:0] = 4'd7; ld_addr_valid = 2'b01; ld_data_ready = 2'b00;
        sample();
        chk("mid_rst_ld_gnt", ld_addr_ready, 2'b01);
        tick();
        ld_addr_valid = 2'b00;
        st_addr = 4'd9; st_data = 32'h99; st_valid = 1'b1; st_done_ready = 1'b0;
        sample();
        chk("mid_rst_st_gnt", st_ready, 1'b1);
        tick();
        st_addr = 4'd7; st_data = 32'hBAD;
        sample();
        chk("mid_rst_pend", {st_done_valid, ld_data_valid}, 3'b101);
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0; st_valid = 1'b0;
        sample();
        chk("mid_rst_valids", {st_done_valid, ld_data_valid}, 3'b000);
        chk("mid_rst_data", ld_data, 64'h0);
        tick();

        for (int i = 0; i < 10; i++) begin
            load0(tbl[i].addr, tbl[i].exp);
        end

        // randomized traffic against the behavioural model
        idle_inputs();
        do_reset();
        m_last = NSLOT - 1;
        m_pend[0] = 1'b0; m_pend[1] = 1'b0; m_done = 1'b0;
        m_data[0] = '0; m_data[1] = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (cyc < DEP) begin
                idle_inputs();
                wr_en = 1'b1; wr_addr = 4'(cyc); wr_data = $urandom;
            end else begin
                ld_addr       = {4'($urandom_range(0, 15)), 4'($urandom_range(0, 15))};
                ld_addr_valid = 2'($urandom_range(0, 3));
                ld_data_ready = 2'($urandom_range(0, 3));
                st_addr       = 4'($urandom_range(0, 15));
                st_data       = $urandom;
                st_valid      = 1'($urandom_range(0, 1));
                st_done_ready = 1'($urandom_range(0, 1));
                wr_en         = ($urandom_range(0, 9) == 0);
                wr_addr       = 4'($urandom_range(0, 15));
                wr_data       = $urandom;
            end
            sample();
            r = {st_valid && !m_done, ld_addr_valid[1] && !m_pend[1], ld_addr_valid[0] && !m_pend[0]};
            win = -1;
            for (int k = 1; k <= NSLOT; k++) begin
                int s;
                s = (m_last + k) % NSLOT;
                if (win < 0 && r[s]) win = s;
            end
            chk("rnd_ld_ready", ld_addr_ready, {win == 1, win == 0});
            chk("rnd_st_ready", st_ready, win == 2);
            chk("rnd_ld_valid", ld_data_valid, {m_pend[1], m_pend[0]});
            chk("rnd_st_done", st_done_valid, m_done);
            for (int i = 0; i < 2; i++) begin
                if (m_pend[i]) chk("rnd_ld_data", ld_data[i*32 +: 32], m_data[i]);
            end
            busy = m_pend[0] || m_pend[1] || m_done;
            for (int i = 0; i < 2; i++) begin
                if (m_pend[i] && ld_data_ready[i]) m_pend[i] = 1'b0;
            end
            if (m_done && st_done_ready) m_done = 1'b0;
            if (win == 0 || win == 1) begin
                int a;
                a = (win == 0) ? int'(ld_addr[3:0]) : int'(ld_addr[7:4]);
                m_pend[win] = 1'b1;
                m_data[win] = (a < DEP) ? m_mem[a] : 32'h0;
            end else if (win == 2) begin
                m_done = 1'b1;
                if (int'(st_addr) < DEP) m_mem[int'(st_addr)] = st_data;
            end else if (wr_en && !busy && int'(wr_addr) < DEP) begin
                m_mem[int'(wr_addr)] = wr_data;
            end
            if (win >= 0) m_last = win;
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
